hazard_ctrl: RTL and testbench

- Central pipeline-control unit for the 5-stage 16-bit CPU; it is the source of the stall and flush controls that the pipeline registers consume.
- Detects load-use hazards, taken-branch redirects, multi-cycle data-memory accesses and HALT drain.
- Drives hold/squash for PC, IF/ID, ID/EX and EX/MEM, and keeps a stall-cycle counter for performance measurement.
- NOP encoding injected by squashing registers is 16'hA000.

---
 rtl/hazard_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush control for the 5-stage 16-bit core
//
// Squashing registers load the NOP encoding 16'hA000; this block only decides
// when they hold or squash.

module hazard_ctrl #(
    parameter int MEM_LAT   = 2,
    parameter int DRAIN_CYC = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  id_rs,
    input  logic        id_rs_used,
    input  logic [3:0]  id_rt,
    input  logic        id_rt_used,
    input  logic [3:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_branch_taken,
    input  logic        mem_access,
    input  logic        id_halt,
    output logic        stall_pc,
    output logic        stall_if,
    output logic        flush_if,
    output logic        bubble_id,
    output logic        stall_mem,
    output logic        halted,
    output logic [15:0] stall_count
);

    localparam int WW = $clog2(MEM_LAT + 1);
    localparam int DW = $clog2(DRAIN_CYC + 1);

    // Counter value loaded on the first stall cycle of a data-memory access
    localparam logic [WW-1:0] FIRST_WAIT = (MEM_LAT > 1) ? WW'(MEM_LAT - 2) : '0;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYC - 1);
    localparam logic          CAN_WAIT   = (MEM_LAT > 1);
    localparam logic          LAT_IS_TWO = (MEM_LAT == 2);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [WW-1:0]   wait_cnt;
    logic            mem_done;
    logic [DW-1:0]   drain_cnt;

    logic            mem_start;
    logic            mem_wait;
    logic            load_use;

    logic            stall_pc_raw;
    logic            stall_if_raw;
    logic            flush_if_raw;
    logic            bubble_id_raw;
    logic            stall_mem_raw;

    // A new access starts stalling only if the previous one has not just completed;
    // mem_done blocks a re-trigger while the same instruction still sits in MEM.
    assign mem_start = CAN_WAIT && mem_access && (wait_cnt == '0) && !mem_done;
    assign mem_wait  = (state != S_HALTED) && (mem_start || (wait_cnt != '0));

    // Register 0 is hard-wired, so a load targeting it never creates a dependency
    assign load_use = ex_is_load && (ex_rd != 4'd0) &&
                      ((id_rs_used && (id_rs == ex_rd)) ||
                       (id_rt_used && (id_rt == ex_rd)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decision; a memory wait freezes every transition
    always_comb begin
        next_state = state;
        case (state)
            S_RUN: begin
                if (!mem_wait && !ex_branch_taken && !load_use && id_halt) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!mem_wait && (drain_cnt == '0)) begin
                    next_state = S_HALTED;
                end
            end
            S_HALTED: begin
                next_state = S_HALTED;
            end
            default: begin
                next_state = S_RUN;
            end
        endcase
    end

    // Stall/flush decode from state plus current inputs, before reset gating
    always_comb begin
        stall_pc_raw  = 1'b0;
        stall_if_raw  = 1'b0;
        flush_if_raw  = 1'b0;
        bubble_id_raw = 1'b0;
        stall_mem_raw = 1'b0;
        if (mem_wait) begin
            stall_pc_raw  = 1'b1;
            stall_if_raw  = 1'b1;
            stall_mem_raw = 1'b1;
        end else begin
            case (state)
                S_RUN: begin
                    if (ex_branch_taken) begin
                        flush_if_raw  = 1'b1;
                        bubble_id_raw = 1'b1;
                    end else if (load_use) begin
                        stall_pc_raw  = 1'b1;
                        stall_if_raw  = 1'b1;
                        bubble_id_raw = 1'b1;
                    end else if (id_halt) begin
                        stall_pc_raw  = 1'b1;
                        flush_if_raw  = 1'b1;
                    end
                end
                S_DRAIN, S_HALTED: begin
                    stall_pc_raw  = 1'b1;
                    stall_if_raw  = 1'b1;
                    bubble_id_raw = 1'b1;
                end
                default: begin
                    stall_pc_raw  = 1'b0;
                end
            endcase
        end
    end

    // While reset is held every control reads as inactive, whatever the inputs do
    assign stall_pc  = rst_n & stall_pc_raw;
    assign stall_if  = rst_n & stall_if_raw;
    assign flush_if  = rst_n & flush_if_raw;
    assign bubble_id = rst_n & bubble_id_raw;
    assign stall_mem = rst_n & stall_mem_raw;

    // Memory-wait counter, drain counter, halted flag and stall statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            mem_done    <= 1'b0;
            drain_cnt   <= '0;
            halted      <= 1'b0;
            stall_count <= 16'd0;
        end else begin
            if (mem_wait) begin
                if (wait_cnt == '0) begin
                    wait_cnt <= FIRST_WAIT;
                    mem_done <= LAT_IS_TWO;
                end else begin
                    wait_cnt <= wait_cnt - WW'(1);
                    mem_done <= (wait_cnt == WW'(1));
                end
            end else begin
                mem_done <= 1'b0;
            end

            if ((state == S_RUN) && (next_state == S_DRAIN)) begin
                drain_cnt <= DRAIN_INIT;
            end else if ((state == S_DRAIN) && !mem_wait && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - DW'(1);
            end

            halted <= (next_state == S_HALTED);

            if (stall_pc_raw && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl

module tb_hazard_ctrl;

    // Expected control vector order: {stall_pc, stall_if, flush_if, bubble_id, stall_mem}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_LU   = 5'b11010;
    localparam logic [4:0] C_BR   = 5'b00110;
    localparam logic [4:0] C_MW   = 5'b11001;
    localparam logic [4:0] C_HLT  = 5'b10100;
    localparam logic [4:0] C_DR   = 5'b11010;

    typedef struct packed {
        logic [4:0]  ctl;
        logic        hlt;
        logic [15:0] sc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  id_rs;
    logic        id_rs_used;
    logic [3:0]  id_rt;
    logic        id_rt_used;
    logic [3:0]  ex_rd;
    logic        ex_is_load;
    logic        ex_branch_taken;
    logic        mem_access;
    logic        id_halt;

    logic        a_stall_pc, a_stall_if, a_flush_if, a_bubble_id, a_stall_mem, a_halted;
    logic [15:0] a_stall_count;
    logic        b_stall_pc, b_stall_if, b_flush_if, b_bubble_id, b_stall_mem, b_halted;
    logic [15:0] b_stall_count;

    logic        sel;
    logic [15:0] exp_sc;
    exp_t        sb[$];
    int          n_tests;
    int          n_fail;

    hazard_ctrl #(.MEM_LAT(3), .DRAIN_CYC(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .id_halt(id_halt),
        .stall_pc(a_stall_pc), .stall_if(a_stall_if), .flush_if(a_flush_if),
        .bubble_id(a_bubble_id), .stall_mem(a_stall_mem), .halted(a_halted),
        .stall_count(a_stall_count)
    );

    hazard_ctrl #(.MEM_LAT(2), .DRAIN_CYC(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .id_halt(id_halt),
        .stall_pc(b_stall_pc), .stall_if(b_stall_if), .flush_if(b_flush_if),
        .bubble_id(b_bubble_id), .stall_mem(b_stall_mem), .halted(b_halted),
        .stall_count(b_stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        id_rs           = 4'd0;
        id_rs_used      = 1'b0;
        id_rt           = 4'd0;
        id_rt_used      = 1'b0;
        ex_rd           = 4'd0;
        ex_is_load      = 1'b0;
        ex_branch_taken = 1'b0;
        mem_access      = 1'b0;
        id_halt         = 1'b0;
    endtask

    // Inputs are already applied at the falling edge; sample 2 units later
    task automatic step(input string tag, input logic [4:0] ctl, input logic hlt);
        exp_t        e;
        logic [4:0]  obs_ctl;
        logic        obs_hlt;
        logic [15:0] obs_sc;
        e.ctl = ctl;
        e.hlt = hlt;
        e.sc  = exp_sc;
        sb.push_back(e);
        #2;
        obs_ctl = sel ? {b_stall_pc, b_stall_if, b_flush_if, b_bubble_id, b_stall_mem}
                      : {a_stall_pc, a_stall_if, a_flush_if, a_bubble_id, a_stall_mem};
        obs_hlt = sel ? b_halted : a_halted;
        obs_sc  = sel ? b_stall_count : a_stall_count;
        e = sb.pop_front();
        check({tag, ".ctl"}, 32'(obs_ctl), 32'(e.ctl));
        check({tag, ".halted"}, 32'(obs_hlt), 32'(e.hlt));
        check({tag, ".stall_count"}, 32'(obs_sc), 32'(e.sc));
        if (e.ctl[4] && rst_n && (exp_sc != 16'hFFFF)) begin
            exp_sc = exp_sc + 16'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sel     = 1'b0;
        exp_sc  = 16'd0;
        rst_n   = 1'b0;
        idle_in();
        @(negedge clk);

        // Reset gating: hazards on the inputs must not leak through
        mem_access = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd5; id_rs = 4'd5; id_rs_used = 1'b1;
        step("rst", C_NONE, 1'b0);
        rst_n = 1'b1;
        idle_in();
        step("idle0", C_NONE, 1'b0);

        // Load-use variants
        ex_is_load = 1'b1; ex_rd = 4'd5; id_rs = 4'd5; id_rs_used = 1'b1;
        step("lu_rs", C_LU, 1'b0);
        idle_in();
        step("idle1", C_NONE, 1'b0);
        ex_is_load = 1'b1; ex_rd = 4'd0; id_rs = 4'd0; id_rs_used = 1'b1;
        step("lu_r0", C_NONE, 1'b0);
        idle_in();
        ex_is_load = 1'b1; ex_rd = 4'd7; id_rt = 4'd7; id_rt_used = 1'b1; id_rs = 4'd2; id_rs_used = 1'b1;
        step("lu_rt", C_LU, 1'b0);
        idle_in();
        ex_is_load = 1'b1; ex_rd = 4'd7; id_rs = 4'd7; id_rs_used = 1'b0; id_rt = 4'd3; id_rt_used = 1'b1;
        step("lu_unused", C_NONE, 1'b0);
        idle_in();
        ex_is_load = 1'b0; ex_rd = 4'd7; id_rs = 4'd7; id_rs_used = 1'b1;
        step("nolu_alu", C_NONE, 1'b0);

        // Branch outranks load-use and halt
        ex_is_load = 1'b1; ex_rd = 4'd7; id_rs = 4'd7; id_rs_used = 1'b1; ex_branch_taken = 1'b1;
        step("br_lu", C_BR, 1'b0);
        idle_in();
        ex_branch_taken = 1'b1; id_halt = 1'b1;
        step("br_halt", C_BR, 1'b0);
        idle_in();
        step("idle2", C_NONE, 1'b0);

        // MEM_LAT=3: two stall cycles per access, back-to-back accesses
        mem_access = 1'b1; ex_branch_taken = 1'b1;
        step("mw1a", C_MW, 1'b0);
        ex_branch_taken = 1'b0;
        step("mw1b", C_MW, 1'b0);
        step("mw1c", C_NONE, 1'b0);
        step("mw2a", C_MW, 1'b0);
        step("mw2b", C_MW, 1'b0);
        mem_access = 1'b0;
        step("mw2c", C_NONE, 1'b0);

        // Halt drain: halted rises four edges after the halt cycle
        id_halt = 1'b1;
        step("halt", C_HLT, 1'b0);
        idle_in();
        step("drain1", C_DR, 1'b0);
        ex_branch_taken = 1'b1;
        step("drain2", C_DR, 1'b0);
        idle_in();
        step("drain3", C_DR, 1'b0);
        ex_branch_taken = 1'b1; mem_access = 1'b1;
        step("halted1", C_DR, 1'b1);
        idle_in();
        step("halted2", C_DR, 1'b1);

        // Reset in the middle of a memory wait
        rst_n  = 1'b0;
        exp_sc = 16'd0;
        step("rst2", C_NONE, 1'b0);
        rst_n = 1'b1;
        mem_access = 1'b1;
        step("mw3a", C_MW, 1'b0);
        rst_n  = 1'b0;
        exp_sc = 16'd0;
        step("rst_wait", C_NONE, 1'b0);
        rst_n = 1'b1;
        idle_in();
        step("post_rst", C_NONE, 1'b0);
        ex_is_load = 1'b1; ex_rd = 4'd9; id_rt = 4'd9; id_rt_used = 1'b1;
        step("post_lu", C_LU, 1'b0);
        idle_in();
        step("post_idle", C_NONE, 1'b0);

        // MEM_LAT=2 instance: single-cycle stall and drain extended by a wait
        sel    = 1'b1;
        rst_n  = 1'b0;
        exp_sc = 16'd0;
        step("b_rst", C_NONE, 1'b0);
        rst_n = 1'b1;
        mem_access = 1'b1;
        step("b_mw_a", C_MW, 1'b0);
        step("b_mw_b", C_NONE, 1'b0);
        mem_access = 1'b0;
        step("b_idle", C_NONE, 1'b0);
        id_halt = 1'b1;
        step("b_halt", C_HLT, 1'b0);
        idle_in();
        step("b_drain1", C_DR, 1'b0);
        mem_access = 1'b1;
        step("b_drain_mw", C_MW, 1'b0);
        step("b_drain2", C_DR, 1'b0);
        mem_access = 1'b0;
        step("b_drain3", C_DR, 1'b0);
        step("b_halted", C_DR, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
